rot_cmd_seq: RTL and testbench

ROT_CMD_SEQ -- requirements
Module: rot_cmd_seq

---
 rtl/rot_cmd_seq.sv | 102 ++++++++++
 tb/tb_rot_cmd_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_cmd_seq.sv
// Queued rotate/shift unit: commands wait in a small FIFO, and the head is evaluated through a
// 5-stage rotate network plus a vacated-bit mask into a registered result with valid/ready.
module rot_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic                     in_dir,
  input  logic [5:0]               in_amt,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]         op_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [39:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic        push, pop;
  logic [39:0] head;
  logic [31:0] h_data;
  logic        h_dir, h_mode;
  logic [5:0]  h_amt;
  logic [31:0] rot [6];
  logic [31:0] mask, result;

  // in_ready looks only at the stored count, never at a same-cycle pop.
  assign in_ready = !rst && (cnt_q < CntW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (cnt_q != '0) && (!out_valid_q || out_ready);

  assign head   = mem_q[rd_ptr_q];
  assign h_data = head[31:0];
  assign h_dir  = head[32];
  assign h_amt  = head[38:33];
  assign h_mode = head[39];

  assign rot[0] = h_data;
  for (genvar g = 0; g < 5; g++) begin : g_rot
    localparam int unsigned Sh = 1 << g;
    assign rot[g+1] = !h_amt[g] ? rot[g] :
                      h_dir     ? {rot[g][Sh-1:0], rot[g][31:Sh]} :
                                  {rot[g][31-Sh:0], rot[g][31:32-Sh]};
  end

  // Shift mode reuses the rotator and clears the bits that wrapped around.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    if (h_mode) begin
      if (h_amt[5])   mask = 32'h0000_0000;
      else if (h_dir) mask = 32'hFFFF_FFFF >> h_amt[4:0];
      else            mask = 32'hFFFF_FFFF << h_amt[4:0];
    end
    result = rot[5] & mask;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_mode, in_amt, in_dir, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      op_cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready) op_cnt_q <= op_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fifo_cnt  = cnt_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_rot_cmd_seq.sv
// Directed bench for rot_cmd_seq: known vectors, FIFO fill/drain, streaming and reset checks.
module tb_rot_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_dir = 1'b0;
  logic [5:0]       in_amt = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [CNT_W-1:0] op_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  rot_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_cnt  (fifo_cnt),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: rotate via a doubled word, shift via native operators.
  function automatic logic [31:0] ref_result(input logic [31:0] d, input logic dir,
                                             input logic [5:0] amt, input logic mode);
    logic [63:0] dd;
    logic [4:0]  a;
    dd = {d, d};
    a  = amt[4:0];
    if (mode) begin
      if (amt >= 6'd32) return 32'h0;
      return dir ? (d >> amt) : (d << amt);
    end
    if (dir) begin
      dd = dd >> a;
      return dd[31:0];
    end
    dd = dd << a;
    return dd[63:32];
  endfunction

  task automatic drive_cmd(input logic [31:0] d, input logic dir, input logic [5:0] amt,
                           input logic mode);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_amt   = amt;
    in_mode  = mode;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic one_cmd(input string tag, input logic [31:0] d, input logic dir,
                         input logic [5:0] amt, input logic mode, input logic [31:0] exp);
    @(negedge clk);
    out_ready = 1'b1;
    drive_cmd(d, dir, amt, mode);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " early_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, " valid"}, out_valid, 1);
    check({tag, " data"}, out_data, exp);
  endtask

  task automatic run_stream(input string tag, input int n, input bit rand_ready,
                            input bit rand_valid);
    int sent = 0, got = 0, gaps = 0, blocked = 0;
    bit started = 0, prev_stall = 0, r, v;
    logic [31:0] prev_data = '0;
    logic [31:0] d;
    logic [5:0]  amt;
    logic        dir, mode;
    for (int cyc = 0; cyc < n * 8 + 20 && got < n; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check({tag, " stall_valid"}, out_valid, 1);
        check({tag, " stall_data"}, out_data, prev_data);
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid) started = 1;
      else if (started) gaps++;
      if (out_valid && r) begin
        if (exp_q.size() == 0) check({tag, " extra_result"}, out_data, 64'hDEAD);
        else check({tag, " data"}, out_data, exp_q.pop_front());
        got++;
      end
      prev_stall = out_valid && !r;
      prev_data  = out_data;
      if (sent < n) begin
        v    = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        d    = $urandom;
        dir  = 1'($urandom_range(0, 1));
        amt  = 6'($urandom_range(0, 63));
        mode = 1'($urandom_range(0, 1));
        drive_cmd(d, dir, amt, mode);
        in_valid = v;
        if (v && in_ready) begin
          exp_q.push_back(ref_result(d, dir, amt, mode));
          sent++;
        end else if (v) begin
          blocked++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " results"}, got, n);
    check({tag, " leftover"}, exp_q.size(), 0);
    check({tag, " op_cnt"}, op_cnt, n);
    check({tag, " idle_after"}, out_valid, 0);
    if (!rand_ready) begin
      check({tag, " gaps"}, gaps, 0);
      check({tag, " blocked"}, blocked, 0);
    end
  endtask

  initial begin
    int acc, got, spurious;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst fifo_cnt", fifo_cnt, 0);
    check("rst op_cnt", op_cnt, 0);
    check("rst in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst in_ready", in_ready, 1);

    one_cmd("rotl1",   32'h8000_0001, 1'b0, 6'd1,  1'b0, 32'h0000_0003);
    one_cmd("rotr4",   32'h1234_5678, 1'b1, 6'd4,  1'b0, 32'h8123_4567);
    one_cmd("shl8",    32'hFFFF_FFFF, 1'b0, 6'd8,  1'b1, 32'hFFFF_FF00);
    one_cmd("shr31",   32'h8000_0000, 1'b1, 6'd31, 1'b1, 32'h0000_0001);
    one_cmd("shl40",   32'hDEAD_BEEF, 1'b0, 6'd40, 1'b1, 32'h0000_0000);
    one_cmd("rotl33",  32'h0000_0001, 1'b0, 6'd33, 1'b0, 32'h0000_0002);
    one_cmd("rotr32",  32'hA5A5_0F0F, 1'b1, 6'd32, 1'b0, 32'hA5A5_0F0F);
    one_cmd("shr32",   32'hFFFF_FFFF, 1'b1, 6'd32, 1'b1, 32'h0000_0000);
    one_cmd("shr4",    32'hF000_000F, 1'b1, 6'd4,  1'b1, 32'h0F00_0000);
    @(negedge clk);
    check("directed op_cnt", op_cnt, 9);

    // Fill with downstream stalled: 1 in output register + DEPTH queued
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_cmd(32'h1111_1111 * (i + 1), 1'(i), 6'(i * 5), 1'b0);
      if (in_ready) begin
        exp_q.push_back(ref_result(32'h1111_1111 * (i + 1), 1'(i), 6'(i * 5), 1'b0));
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("fill accepted", acc, 5);
    check("fill in_ready", in_ready, 0);
    check("fill fifo_cnt", fifo_cnt, 4);
    check("fill out_valid", out_valid, 1);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      if (out_valid) begin
        check("drain data", out_data, exp_q.pop_front());
        got++;
      end
      @(negedge clk);
    end
    check("drain count", got, 5);
    check("drain op_cnt", op_cnt, 5);
    check("drain fifo_cnt", fifo_cnt, 0);
    check("drain out_valid", out_valid, 0);

    do_reset();
    run_stream("stream", 100, 1'b0, 1'b0);
    do_reset();
    run_stream("random", 80, 1'b1, 1'b1);

    // Reset mid-stream with queued work and a held result
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_cmd(32'h0000_00F0 + i, 1'b0, 6'd4, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("mid fifo_cnt", fifo_cnt, 3);
    check("mid out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst out_valid", out_valid, 0);
    check("mid_rst out_data", out_data, 0);
    check("mid_rst fifo_cnt", fifo_cnt, 0);
    check("mid_rst op_cnt", op_cnt, 0);
    check("mid_rst in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("mid spurious", spurious, 0);
    one_cmd("mid cmd", 32'h0000_0010, 1'b1, 6'd4, 1'b1, 32'h0000_0001);
    @(negedge clk);
    check("mid op_cnt", op_cnt, 1);
    check("mid idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
